// File: rtl/hssl_pkt_dispatcher.sv
// Routes an event-packet stream by key into one of NUM_CHANNELS per-channel FIFOs.
// Unroutable packets and packets stalled too long on a full channel are dropped and counted.
module hssl_pkt_dispatcher #(
    parameter int PACKET_BITS  = 72,
    parameter int NUM_CHANNELS = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [PACKET_BITS-1:0]                      pkt_data_in,
    input  logic                                        pkt_vld_in,
    output logic                                        pkt_rdy_out,
    input  logic [NUM_CHANNELS-1:0][31:0]               route_key_in,
    input  logic [NUM_CHANNELS-1:0][31:0]               route_mask_in,
    input  logic [NUM_CHANNELS-1:0]                     route_en_in,
    input  logic [7:0]                                  drop_wait_in,
    output logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0]    txpkt_data_out,
    output logic [NUM_CHANNELS-1:0]                     txpkt_vld_out,
    input  logic [NUM_CHANNELS-1:0]                     txpkt_rdy_in,
    output logic [31:0]                                 miss_cnt_out,
    output logic [31:0]                                 drop_cnt_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic {EMPTY, HELD} state_t;

    state_t                   state_reg, state_next;
    logic [PACKET_BITS-1:0]   hold_data_reg;
    logic [CW-1:0]            hold_ch_reg;
    logic                     hold_hit_reg;
    logic [7:0]               wait_cnt_reg, wait_cnt_next;
    logic [31:0]              miss_cnt_reg, drop_cnt_reg;

    logic [NUM_CHANNELS-1:0]  route_hit;
    logic                     route_found;
    logic [CW-1:0]            route_ch;
    logic [NUM_CHANNELS-1:0]  fifo_full;
    logic [NUM_CHANNELS-1:0]  fifo_push;
    logic                     release_now;
    logic                     miss_inc;
    logic                     drop_inc;
    logic                     pkt_rdy;
    logic                     in_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_match
            assign route_hit[gi] = route_en_in[gi] &&
                                   ((pkt_data_in[39:8] & route_mask_in[gi]) == route_key_in[gi]);
        end
    endgenerate

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        route_found = 1'b0;
        route_ch    = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (route_hit[i]) begin
                route_found = 1'b1;
                route_ch    = CW'(i);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        release_now   = 1'b0;
        miss_inc      = 1'b0;
        drop_inc      = 1'b0;
        fifo_push     = '0;
        if (state_reg == HELD) begin
            if (!hold_hit_reg) begin
                release_now = 1'b1;
                miss_inc    = 1'b1;
            end else if (!fifo_full[hold_ch_reg]) begin
                release_now            = 1'b1;
                fifo_push[hold_ch_reg] = 1'b1;
            end else if (drop_wait_in != 8'd0 && wait_cnt_reg == drop_wait_in - 8'd1) begin
                release_now = 1'b1;
                drop_inc    = 1'b1;
            end else begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
        end
        if (release_now) begin
            wait_cnt_next = 8'd0;
            state_next    = EMPTY;
        end
        pkt_rdy = (state_reg == EMPTY) || release_now;
        in_xfer = pkt_vld_in && pkt_rdy;
        if (in_xfer) begin
            state_next = HELD;
        end
    end

    assign pkt_rdy_out = pkt_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= EMPTY;
            hold_data_reg <= '0;
            hold_ch_reg   <= '0;
            hold_hit_reg  <= 1'b0;
            wait_cnt_reg  <= 8'd0;
            miss_cnt_reg  <= 32'd0;
            drop_cnt_reg  <= 32'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (in_xfer) begin
                hold_data_reg <= pkt_data_in;
                hold_ch_reg   <= route_ch;
                hold_hit_reg  <= route_found;
            end
            if (miss_inc && miss_cnt_reg != 32'hFFFF_FFFF) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
            if (drop_inc && drop_cnt_reg != 32'hFFFF_FFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 32'd1;
            end
        end
    end

    assign miss_cnt_out = miss_cnt_reg;
    assign drop_cnt_out = drop_cnt_reg;

    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_fifo
            logic [PACKET_BITS-1:0] mem [FIFO_DEPTH];
            logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
            logic                   empty;
            logic                   pop;

            assign empty         = (wr_ptr_reg == rd_ptr_reg);
            assign fifo_full[gi] = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            assign pop           = !empty && txpkt_rdy_in[gi];

            always_ff @(posedge clk) begin
                if (fifo_push[gi]) begin
                    mem[wr_ptr_reg[AW-1:0]] <= hold_data_reg;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (fifo_push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                end
            end

            // Memory contents survive reset, so an empty FIFO presents zero data.
            assign txpkt_vld_out[gi]  = !empty;
            assign txpkt_data_out[gi] = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
        end
    endgenerate

endmodule

// File: tb/tb_hssl_pkt_dispatcher.sv
// Directed bench for hssl_pkt_dispatcher: routing, ordering, latency, miss/drop counting and reset.
`timescale 1ns/1ps
module tb_hssl_pkt_dispatcher;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [71:0]           pkt_data;
    logic                  pkt_vld;
    logic                  pkt_rdy;
    logic [7:0][31:0]      rkey;
    logic [7:0][31:0]      rmask;
    logic [7:0]            ren;
    logic [7:0]            drop_wait;
    logic [7:0][71:0]      tdata;
    logic [7:0]            tvld;
    logic [7:0]            trdy;
    logic [31:0]           miss_cnt;
    logic [31:0]           drop_cnt;

    int errors = 0;
    int checks = 0;
    logic [71:0] rxq [8][$];

    hssl_pkt_dispatcher #(.PACKET_BITS(72), .NUM_CHANNELS(8), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pkt_data_in    (pkt_data),
        .pkt_vld_in     (pkt_vld),
        .pkt_rdy_out    (pkt_rdy),
        .route_key_in   (rkey),
        .route_mask_in  (rmask),
        .route_en_in    (ren),
        .drop_wait_in   (drop_wait),
        .txpkt_data_out (tdata),
        .txpkt_vld_out  (tvld),
        .txpkt_rdy_in   (trdy),
        .miss_cnt_out   (miss_cnt),
        .drop_cnt_out   (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 8; c++) begin
                if (tvld[c] && trdy[c]) rxq[c].push_back(tdata[c]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] pk(input logic [31:0] key, input logic [31:0] pay);
        return {pay, key, 8'h5A};
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [71:0] d, input int budget, output int waited);
        pkt_data = d;
        pkt_vld  = 1'b1;
        #1;
        waited = 0;
        while (!pkt_rdy && waited < budget) begin
            tick();
            waited++;
        end
        check("accept", 72'(pkt_rdy), 72'd1);
        @(posedge clk);
        #1;
        pkt_vld = 1'b0;
    endtask

    initial begin
        int w;
        int n;
        int base;
        reset     = 1'b1;
        pkt_data  = '0;
        pkt_vld   = 1'b0;
        rkey      = '0;
        rmask     = '0;
        ren       = 8'h00;
        drop_wait = 8'd0;
        trdy      = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_rdy",  72'(pkt_rdy), 72'd1);
        check("rst_vld",  72'(tvld), 72'd0);
        check("rst_miss", 72'(miss_cnt), 72'd0);
        check("rst_drop", 72'(drop_cnt), 72'd0);
        reset = 1'b0;
        tick();

        // T1: everything to ch0, first vld two cycles after accept, back-to-back accepts
        ren = 8'h01;
        pkt_data = pk(32'd0, 32'hC0DE_0000);
        pkt_vld  = 1'b1;
        #1;
        check("t1_rdy0", 72'(pkt_rdy), 72'd1);
        tick();
        check("t1_vld_n1", 72'(tvld[0]), 72'd0);
        pkt_data = pk(32'd1, 32'hC0DE_0001);
        #1;
        check("t1_rdy1", 72'(pkt_rdy), 72'd1);
        tick();
        check("t1_vld_n2", 72'(tvld[0]), 72'd1);
        pkt_vld = 1'b0;
        for (int i = 2; i < 10; i++) begin
            send(pk(i, 32'hC0DE_0000 + i), 5, w);
            check("t1_b2b", 72'(w), 72'd0);
        end
        idle(6);
        check("t1_count", 72'(rxq[0].size()), 72'd10);
        for (int i = 0; i < 10 && i < rxq[0].size(); i++) begin
            check("t1_data", rxq[0][i], pk(i, 32'hC0DE_0000 + i));
        end

        // T2: masked key match on ch3, non-matching key is counted as a miss
        ren      = 8'h08;
        rkey[3]  = 32'h0000_0300;
        rmask[3] = 32'h0000_FF00;
        send(pk(32'h1234_0300, 32'hAAAA_0001), 5, w);
        send(pk(32'h1234_0400, 32'hAAAA_0002), 5, w);
        idle(5);
        check("t2_miss", 72'(miss_cnt), 72'd1);
        check("t2_ch3_count", 72'(rxq[3].size()), 72'd1);
        if (rxq[3].size() > 0) check("t2_ch3_data", rxq[3][0], pk(32'h1234_0300, 32'hAAAA_0001));
        check("t2_ch0_count", 72'(rxq[0].size()), 72'd10);

        // T3: ch0 and ch5 both match, lowest index wins
        ren      = 8'h21;
        rkey[0]  = '0; rmask[0] = '0;
        rkey[5]  = '0; rmask[5] = '0;
        for (int i = 0; i < 3; i++) send(pk(32'hBEEF_0000 + i, 32'h3333_0000 + i), 5, w);
        idle(5);
        check("t3_ch0_count", 72'(rxq[0].size()), 72'd13);
        check("t3_ch5_count", 72'(rxq[5].size()), 72'd0);
        if (rxq[0].size() == 13) check("t3_ch0_last", rxq[0][12], pk(32'hBEEF_0002, 32'h3333_0002));

        // T4: ch2 blocked, 8-cycle timeout drops the 5th and 6th packets
        ren       = 8'h04;
        rkey[2]   = '0; rmask[2] = '0;
        trdy[2]   = 1'b0;
        drop_wait = 8'd8;
        for (int i = 1; i <= 5; i++) begin
            send(pk(32'h4400_0000 + i, 32'h4444_0000 + i), 5, w);
            check("t4_fill_wait", 72'(w), 72'd0);
        end
        pkt_data = pk(32'h4400_0006, 32'h4444_0006);
        pkt_vld  = 1'b1;
        #1;
        check("t4_stall_rdy", 72'(pkt_rdy), 72'd0);
        send(pk(32'h4400_0006, 32'h4444_0006), 20, w);
        check("t4_wait5", 72'(w), 72'd7);
        check("t4_drop1", 72'(drop_cnt), 72'd1);
        n = 0;
        while (!pkt_rdy && n < 20) begin
            tick();
            n++;
        end
        check("t4_wait6", 72'(n), 72'd7);
        check("t4_drop1_hold", 72'(drop_cnt), 72'd1);
        tick();
        check("t4_drop2", 72'(drop_cnt), 72'd2);
        check("t4_empty_rdy", 72'(pkt_rdy), 72'd1);
        check("t4_ch2_none", 72'(rxq[2].size()), 72'd0);
        trdy[2] = 1'b1;
        idle(8);
        check("t4_ch2_count", 72'(rxq[2].size()), 72'd4);
        for (int i = 0; i < 4 && i < rxq[2].size(); i++) begin
            check("t4_ch2_data", rxq[2][i], pk(32'h4400_0001 + i, 32'h4444_0001 + i));
        end

        // T5: drop_wait=0 never drops; backpressure holds until ch1 drains
        drop_wait = 8'd0;
        ren       = 8'h02;
        rkey[1]   = '0; rmask[1] = '0;
        trdy[1]   = 1'b0;
        for (int i = 1; i <= 5; i++) send(pk(32'h5500_0000 + i, 32'h5555_0000 + i), 5, w);
        pkt_data = pk(32'h5500_0006, 32'h5555_0006);
        pkt_vld  = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pkt_rdy) n++;
        end
        check("t5_rdy_low", 72'(n), 72'd0);
        check("t5_no_drop", 72'(drop_cnt), 72'd2);
        trdy[1] = 1'b1;
        send(pk(32'h5500_0006, 32'h5555_0006), 10, w);
        idle(10);
        check("t5_count", 72'(rxq[1].size()), 72'd6);
        for (int i = 0; i < 6 && i < rxq[1].size(); i++) begin
            check("t5_data", rxq[1][i], pk(32'h5500_0001 + i, 32'h5555_0001 + i));
        end

        // T6: reset mid-burst discards queued and held packets
        ren     = 8'h04;
        trdy[2] = 1'b0;
        base    = rxq[2].size();
        for (int i = 1; i <= 3; i++) send(pk(32'h6600_0000 + i, 32'h6666_0000 + i), 5, w);
        check("t6_pre_vld", 72'(tvld[2]), 72'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_vld",  72'(tvld), 72'd0);
        check("t6_rst_miss", 72'(miss_cnt), 72'd0);
        check("t6_rst_drop", 72'(drop_cnt), 72'd0);
        check("t6_rst_rdy",  72'(pkt_rdy), 72'd1);
        check("t6_rst_data", tdata[2], 72'd0);
        tick();
        reset   = 1'b0;
        trdy[2] = 1'b1;
        idle(4);
        check("t6_discard", 72'(rxq[2].size()), 72'(base));
        send(pk(32'h7700_0001, 32'h7777_0001), 5, w);
        idle(4);
        check("t6_restart_count", 72'(rxq[2].size()), 72'(base + 1));
        if (rxq[2].size() == base + 1) check("t6_restart_data", rxq[2][base], pk(32'h7700_0001, 32'h7777_0001));
        check("t6_miss_after", 72'(miss_cnt), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
